// File: rtl/stepper_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stepper_move_sequencer
// Brief    : Two-axis step/dir pulse sequencer serving a move request; the
//            MOTOR_CLAMP_EN macro saturates each |steps| to MAX_STEPS.
// Revision : 1.0 - initial release
// ============================================================================
module stepper_move_sequencer #(
  parameter int HALF_PERIOD = 50000,
  parameter int DIR_SETUP   = 100,
  parameter int MAX_STEPS   = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor_driver,
  input  logic [15:0] x_steps,
  input  logic [15:0] y_steps,
  output logic        x_step,
  output logic        x_dir,
  output logic        y_step,
  output logic        y_dir,
  output logic        motor_ready,
  output logic        busy
);

`ifdef MOTOR_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam int TMAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] HP_LOAD = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] DS_LOAD = TW'(DIR_SETUP - 1);
  localparam logic [15:0]   CLAMP_V = 16'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [15:0]   x_cnt_q, y_cnt_q;
  logic          x_step_q, y_step_q, x_dir_q, y_dir_q, ready_q, busy_q;

  logic [15:0]   x_mag_d, y_mag_d, x_dec_d, y_dec_d;
  logic          timer_done_d;

  // Two's-complement magnitude; -32768 maps to 32768 in the unsigned result.
  function automatic logic [15:0] magnitude(input logic [15:0] v);
    logic [15:0] m;
    m = v[15] ? (~v + 16'd1) : v;
    if (CLAMP_EN && (m > CLAMP_V)) m = CLAMP_V;
    return m;
  endfunction

  always_comb begin
    x_mag_d      = magnitude(x_steps);
    y_mag_d      = magnitude(y_steps);
    x_dec_d      = (x_cnt_q != 16'd0) ? (x_cnt_q - 16'd1) : 16'd0;
    y_dec_d      = (y_cnt_q != 16'd0) ? (y_cnt_q - 16'd1) : 16'd0;
    timer_done_d = (timer_q == '0);
  end

  // Outputs are registered alongside each state transition so they change
  // exactly on state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      x_cnt_q  <= 16'd0;
      y_cnt_q  <= 16'd0;
      x_step_q <= 1'b0;
      y_step_q <= 1'b0;
      x_dir_q  <= 1'b0;
      y_dir_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (motor_driver) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          x_cnt_q <= x_mag_d;
          y_cnt_q <= y_mag_d;
          x_dir_q <= x_steps[15];
          y_dir_q <= y_steps[15];
          if ((x_mag_d == 16'd0) && (y_mag_d == 16'd0)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_SETUP;
            timer_q <= DS_LOAD;
          end
        end
        S_SETUP: begin
          if (timer_done_d) begin
            state_q  <= S_HIGH;
            timer_q  <= HP_LOAD;
            x_step_q <= (x_cnt_q != 16'd0);
            y_step_q <= (y_cnt_q != 16'd0);
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_HIGH: begin
          if (timer_done_d) begin
            state_q  <= S_LOW;
            timer_q  <= HP_LOAD;
            x_step_q <= 1'b0;
            y_step_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_LOW: begin
          if (timer_done_d) begin
            x_cnt_q <= x_dec_d;
            y_cnt_q <= y_dec_d;
            if ((x_dec_d == 16'd0) && (y_dec_d == 16'd0)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q  <= S_HIGH;
              timer_q  <= HP_LOAD;
              x_step_q <= (x_dec_d != 16'd0);
              y_step_q <= (y_dec_d != 16'd0);
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_DONE: begin
          if (!motor_driver) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          x_step_q <= 1'b0;
          y_step_q <= 1'b0;
          ready_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign x_step      = x_step_q;
  assign y_step      = y_step_q;
  assign x_dir       = x_dir_q;
  assign y_dir       = y_dir_q;
  assign motor_ready = ready_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_stepper_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stepper_move_sequencer
// Brief    : Scoreboard bench for stepper_move_sequencer (MOTOR_CLAMP_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stepper_move_sequencer;
  localparam int HP   = 2;
  localparam int DS   = 1;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        motor_driver;
  logic [15:0] x_steps, y_steps;
  logic        x_step, x_dir, y_step, y_dir, motor_ready, busy;

  stepper_move_sequencer #(.HALF_PERIOD(HP), .DIR_SETUP(DS), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .reset(reset), .motor_driver(motor_driver),
    .x_steps(x_steps), .y_steps(y_steps),
    .x_step(x_step), .x_dir(x_dir), .y_step(y_step), .y_dir(y_dir),
    .motor_ready(motor_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int xn;
    int yn;
    bit xd;
    bit yd;
    int lat;
    int start;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: number of pulses per axis is the (optionally clamped) magnitude.
  function automatic int ref_mag(input logic signed [15:0] v);
    int m;
    m = (v < 0) ? -int'(v) : int'(v);
`ifdef MOTOR_CLAMP_EN
    if (m > MAXS) m = MAXS;
`endif
    return m;
  endfunction

  // Monitor: counts pulses, checks widths, and scores each completed move.
  int xp, yp, xw, yw, rlen;
  bit xprev, yprev, rprev;
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      xp = 0; yp = 0; xw = 0; yw = 0; rlen = 0;
      xprev = 1'b0; yprev = 1'b0; rprev = 1'b0;
    end else begin
      if (x_step) begin
        if (!xprev) xp++;
        xw++;
      end else if (xprev) begin
        check("x_width", xw, HP);
        xw = 0;
      end
      if (y_step) begin
        if (!yprev) yp++;
        yw++;
      end else if (yprev) begin
        check("y_width", yw, HP);
        yw = 0;
      end
      if (motor_ready) begin
        rlen++;
        if (!rprev) begin
          check("busy_in_done", busy, 0);
          check("ready_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("x_pulses", xp, mon_e.xn);
            check("y_pulses", yp, mon_e.yn);
            check("x_dir", x_dir, mon_e.xd);
            check("y_dir", y_dir, mon_e.yd);
            check("latency", cyc - mon_e.start, mon_e.lat);
          end
          xp = 0;
          yp = 0;
        end
      end else if (rprev) begin
        check("ready_len", rlen, 1);
        check("busy_after_done", busy, 0);
        rlen = 0;
      end
      xprev = x_step;
      yprev = y_step;
      rprev = motor_ready;
    end
  end

  // Latency is counted in clock edges from the cycle in which motor_driver
  // is driven high (the DUT samples it on the first following edge).
  task automatic do_move(input logic signed [15:0] x, input logic signed [15:0] y,
                         input bit drop_mid, input bit chg_setup);
    exp_t e;
    int   n;
    bit   seen;
    e.xn    = ref_mag(x);
    e.yn    = ref_mag(y);
    e.xd    = (x < 0);
    e.yd    = (y < 0);
    n       = (e.xn > e.yn) ? e.xn : e.yn;
    e.lat   = (n == 0) ? 2 : (2 + DS + 2 * HP * n);
    e.start = cyc;
    exp_q.push_back(e);
    x_steps      = x;
    y_steps      = y;
    motor_driver = 1'b1;
    seen         = 1'b0;
    for (int i = 0; i < e.lat + 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        x_steps = chg_setup ? 16'd7 : 16'($urandom);
        y_steps = chg_setup ? y_steps : 16'($urandom);
      end
      if (drop_mid && i == 4) motor_driver = 1'b0;
      if (motor_ready) seen = 1'b1;
    end
    if (!seen) begin
      check("ready_timeout", motor_ready, 1);
      exp_q.delete();
      reset = 1'b1;
      motor_driver = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      return;
    end
    motor_driver = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    motor_driver = 1'b0;
    x_steps      = 16'd0;
    y_steps      = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x_step", x_step, 0);
    check("rst_y_step", y_step, 0);
    check("rst_x_dir", x_dir, 0);
    check("rst_y_dir", y_dir, 0);
    check("rst_ready", motor_ready, 0);
    check("rst_busy", busy, 0);

    mon_en = 1'b1;
    do_move(16'sd3, -16'sd2, 1'b0, 1'b0);
    do_move(16'sd0, 16'sd0, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    do_move(16'sd2, 16'sd0, 1'b1, 1'b0);
    @(negedge clk);
    check("idle_after_drop", busy, 0);
    do_move(16'sd2, 16'sd0, 1'b0, 1'b1);

    // Back-to-back random moves, re-requesting right after each DONE.
    for (int k = 0; k < 12; k++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 12)) - 6;
      ry = int'($urandom_range(0, 12)) - 6;
      do_move(16'(rx), 16'(ry), 1'b0, 1'b0);
    end

`ifdef MOTOR_CLAMP_EN
    do_move(16'sh8000, 16'sd1, 1'b0, 1'b0);
`else
    mon_en       = 1'b0;
    x_steps      = 16'h8000;
    y_steps      = 16'd1;
    motor_driver = 1'b1;
    repeat (2) @(negedge clk);
    check("x_cnt_32768", dut.x_cnt_q, 32768);
    check("y_cnt_1", dut.y_cnt_q, 1);
    check("x_dir_neg", x_dir, 1);
    reset        = 1'b1;
    motor_driver = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    // Reset during the second HIGH phase of a 5-step move.
    mon_en       = 1'b0;
    x_steps      = 16'd5;
    y_steps      = 16'd0;
    motor_driver = 1'b1;
    repeat (7) @(negedge clk);
    check("x_step_2nd_high", x_step, 1);
    reset        = 1'b1;
    motor_driver = 1'b0;
    @(negedge clk);
    check("abort_x_step", x_step, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", motor_ready, 0);
    check("abort_x_dir", x_dir, 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_abort_quiet", {x_step, busy, motor_ready}, 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
